efpga_op_responder: RTL and testbench
=====================================

# efpga_op_responder

Fabric-side responder for the Forte core's eFPGA accelerator interface. Accepts the operand/operator/delay command issued by the core's eFPGA port, executes one of four operations, and returns three result words plus a done level. Instantiated inside the eFPGA region as the reference accelerator, and used standalone as the bench model for the core's eFPGA initiator.

## Interface
Parameters:
- MUL_CYCLES, 32: iterations of the sequential multiplier; fixed at 32 for 32-bit operands.

Ports:
- clk_i  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- eFPGA_en_i  in  1  accelerator enable; low aborts any operation
- eFPGA_write_strobe_i  in  1  command strobe, sampled on clk_i
- eFPGA_operand_a_i  in  32  operand A
- eFPGA_operand_b_i  in  32  operand B
- eFPGA_operator_i  in  2  operation select
- eFPGA_delay_i  in  4  extra wait cycles before done
- eFPGA_result_a_o  out  32  primary result
- eFPGA_result_b_o  out  32  secondary result
- eFPGA_result_c_o  out  32  status/flags word
- eFPGA_fpga_done_o  out  1  result-valid level

## Operation
- Command accepted on an edge where en=1, strobe=1, state is IDLE or DONE. Accept latches operands, operator, and delay; clears done and sticky overrun.
- Operators:
  - 00 ADD: a = A+B, b = A−B.
  - 01 MUL: {b,a} = unsigned 64-bit A×B.
  - 10 LOGIC: a = A&B, b = A^B.
  - 11 MINMAX: a = signed min, b = signed max.
- result_c bits:
  - [0] zero: result_a==0.
  - [1] carry-out of A+B (op 00 only, else 0).
  - [2] signed overflow of A+B (op 00 only, else 0).
  - [3] result_a[31].
  - [4] A<B signed.
  - [5] A<B unsigned.
  - [6] A==B.
  - [7] MUL requested but not compiled in.
  - [8] overrun: strobe seen while EXEC/MUL/WAIT; sticky until next accept.
  - [15:9] 0.
  - [19:16] latched delay.
  - [31:20] completed-operation counter, wraps 4095→0.
- States:
  - IDLE → EXEC on accept.
  - EXEC → MUL if op 01 and MUL compiled in; else → WAIT if delay≠0; else → DONE.
  - MUL → WAIT/DONE (same delay rule) when the multiplier finishes.
  - WAIT counts delay down to 1, then → DONE.
  - DONE holds until next accept (→ EXEC).
- en low in any state: next edge → IDLE. Done clears. Results hold last values. Counter not incremented.
- Strobe while busy: ignored, sets overrun; operation continues unaffected.

## Timing
- Reset: all results 0, done 0, state IDLE, counter 0, overrun 0.
- Accept at edge T. Results, flags, and counter are registered and done rises together:
  - non-MUL ops: at edge T+1+delay.
  - MUL: at edge T+1+MUL_CYCLES+delay (T+33+delay).
- Results are stable while done=1. They change only on a completing edge or reset.
- Accept while in DONE: done falls at edge T. This is a back-to-back command with no bubble.
- Strobe coincident with en falling: en wins; no accept.
- Reset mid-operation: immediate asynchronous clear; no done.

## Configuration
- EFPGA_RESP_MUL_EN defined: efpga_seq_mul instantiated; op 01 computes the 64-bit product with the latency above.
- Not defined: no multiplier logic. Op 01 completes like a non-MUL op with a=b=0 and result_c[7]=1.

## Structure
- Package efpga_resp_pkg holds:
  - operator encodings (OP_ADD, OP_MUL, OP_LOGIC, OP_MINMAX)
  - state enum
  - result_c bit-index constants
  - MUL_CYCLES default
- Sub-module efpga_seq_mul: radix-2 shift-add unsigned 32×32 multiplier with start/busy/done, 32 iterations, product held until the next start.

## Test plan
- Reset release, no strobe → all outputs 0, done 0 indefinitely.
- ADD, A=0xFFFFFFFF, B=1, delay=0 → done at T+1; a=0, b=0xFFFFFFFE, c[0]=1, c[1]=1, c[2]=0, c[20]=1.
- MUL (EFPGA_RESP_MUL_EN), A=0xFFFFFFFF, B=0xFFFFFFFF, delay=3 → done at T+36; a=0x00000001, b=0xFFFFFFFE. Without the macro → done at T+4, a=b=0, c[7]=1.
- MINMAX, A=0x80000000, B=5, delay=2; second strobe at T+1 → done at T+3; a=0x80000000, b=5, c[4]=1, c[5]=0, c[8]=1; second command ignored.
- LOGIC accepted, delay=15; en dropped at T+5 → IDLE at T+6, done never rises, results keep prior values, counter unchanged.
- Back-to-back: strobe on the DONE cycle with a new ADD → done falls at that edge and rises one cycle later with new results; 4096 completions wrap c[31:20] to 0.

Source files
------------

// File: rtl/efpga_resp_pkg.sv
// efpga_resp_pkg: shared encodings, state type, result_c bit positions and
// the shift-add step used by the sequential multiplier of efpga_op_responder.
package efpga_resp_pkg;

   localparam int MUL_CYCLES_DEF = 32;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_MUL    = 2'b01;
   localparam logic [1:0] OP_LOGIC  = 2'b10;
   localparam logic [1:0] OP_MINMAX = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EXEC = 3'd1,
      ST_MUL  = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } resp_state_t;

   localparam int C_ZERO   = 0;
   localparam int C_CARRY  = 1;
   localparam int C_OVF    = 2;
   localparam int C_NEG    = 3;
   localparam int C_SLT    = 4;
   localparam int C_ULT    = 5;
   localparam int C_EQ     = 6;
   localparam int C_NOMUL  = 7;
   localparam int C_OVR    = 8;
   localparam int C_DLY_LO = 16;
   localparam int C_CNT_LO = 20;

   // One radix-2 iteration: conditionally add the multiplicand into the
   // upper half, then shift the whole 65-bit partial product right by one.
   function automatic logic [63:0] mul_step(input logic [63:0] prod,
                                            input logic [31:0] mcand);
      logic [32:0] sum;
      sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
      return {sum, prod[31:1]};
   endfunction

endpackage

// File: rtl/efpga_seq_mul.sv
// efpga_seq_mul: radix-2 shift-add unsigned 32x32 multiplier. The first
// iteration is folded into the start edge, so done rises MUL_CYCLES-1 edges
// after start and the product is held until the next start.
module efpga_seq_mul
   import efpga_resp_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] product_o
);

   logic [63:0] prod_r;
   logic [31:0] mcand_r;
   logic [5:0]  iter_r;
   logic        busy_r;
   logic        done_r;

   // Iteration register: load on start, one shift-add step per busy cycle.
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         prod_r  <= 64'd0;
         mcand_r <= 32'd0;
         iter_r  <= 6'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (start_i) begin
         mcand_r <= a_i;
         prod_r  <= mul_step({32'd0, b_i}, a_i);
         iter_r  <= 6'd1;
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else if (busy_r) begin
         prod_r <= mul_step(prod_r, mcand_r);
         iter_r <= iter_r + 6'd1;
         if (iter_r == 6'(MUL_CYCLES - 1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
         end
      end else begin
         prod_r <= prod_r;
      end
   end

   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign product_o = prod_r;

endmodule

// File: rtl/efpga_op_responder.sv
// efpga_op_responder: fabric-side eFPGA accelerator responder. Executes
// ADD/MUL/LOGIC/MINMAX on a latched command and returns three registered
// result words plus a done level.
// Optional feature macro: EFPGA_RESP_MUL_EN (sequential multiplier for op 01).
module efpga_op_responder
   import efpga_resp_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        eFPGA_en_i,
   input  logic        eFPGA_write_strobe_i,
   input  logic [31:0] eFPGA_operand_a_i,
   input  logic [31:0] eFPGA_operand_b_i,
   input  logic [1:0]  eFPGA_operator_i,
   input  logic [3:0]  eFPGA_delay_i,
   output logic [31:0] eFPGA_result_a_o,
   output logic [31:0] eFPGA_result_b_o,
   output logic [31:0] eFPGA_result_c_o,
   output logic        eFPGA_fpga_done_o
);

   resp_state_t state_r, state_next_s;
   logic [3:0]  wait_r, wait_next_s;
   logic        done_r, done_next_s;
   logic        overrun_r, overrun_next_s;
   logic [1:0]  op_r;
   logic [31:0] a_r, b_r;
   logic [3:0]  dly_r;
   logic [11:0] cnt_r;
   logic [31:0] res_a_r, res_b_r, res_c_r;

   logic        accept_s, complete_s, mul_start_s, mul_done_s;
   logic [63:0] mul_prod_s;
   logic [31:0] res_a_s, res_b_s, res_c_s;
   logic        carry_s, ovf_s, nomul_s;

`ifdef EFPGA_RESP_MUL_EN
   localparam logic MUL_PRESENT = 1'b1;
   logic mul_busy_unused_s;

   efpga_seq_mul #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk_i     (clk_i),
      .reset     (reset),
      .start_i   (mul_start_s),
      .a_i       (a_r),
      .b_i       (b_r),
      .busy_o    (mul_busy_unused_s),
      .done_o    (mul_done_s),
      .product_o (mul_prod_s)
   );
`else
   localparam logic MUL_PRESENT = 1'b0;
   logic unused_mul_s;

   assign mul_done_s   = 1'b0;
   assign mul_prod_s   = 64'd0;
   assign unused_mul_s = mul_start_s | (MUL_CYCLES != 32);
`endif

   // Next-state logic: enable abort, accept, overrun marking and delay countdown.
   always_comb begin
      state_next_s   = state_r;
      wait_next_s    = wait_r;
      done_next_s    = done_r;
      overrun_next_s = overrun_r;
      accept_s       = 1'b0;
      complete_s     = 1'b0;
      mul_start_s    = 1'b0;
      if (!eFPGA_en_i) begin
         state_next_s = ST_IDLE;
         done_next_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (eFPGA_write_strobe_i) begin
                  accept_s       = 1'b1;
                  state_next_s   = ST_EXEC;
                  done_next_s    = 1'b0;
                  overrun_next_s = 1'b0;
               end else begin
                  state_next_s = state_r;
               end
            end
            ST_EXEC, ST_MUL: begin
               overrun_next_s = overrun_r | eFPGA_write_strobe_i;
               if (state_r == ST_EXEC && op_r == OP_MUL && MUL_PRESENT) begin
                  mul_start_s  = 1'b1;
                  state_next_s = ST_MUL;
               end else if (state_r == ST_MUL && !mul_done_s) begin
                  state_next_s = ST_MUL;
               end else if (dly_r != 4'd0) begin
                  state_next_s = ST_WAIT;
                  wait_next_s  = dly_r;
               end else begin
                  state_next_s = ST_DONE;
                  complete_s   = 1'b1;
                  done_next_s  = 1'b1;
               end
            end
            ST_WAIT: begin
               overrun_next_s = overrun_r | eFPGA_write_strobe_i;
               if (wait_r == 4'd1) begin
                  state_next_s = ST_DONE;
                  complete_s   = 1'b1;
                  done_next_s  = 1'b1;
               end else begin
                  wait_next_s = wait_r - 4'd1;
               end
            end
            default: begin
               state_next_s = ST_IDLE;
               done_next_s  = 1'b0;
            end
         endcase
      end
   end

   // Result datapath computed from the latched command.
   always_comb begin
      logic [32:0] sum_v;
      logic        slt_v;
      sum_v   = {1'b0, a_r} + {1'b0, b_r};
      slt_v   = $signed(a_r) < $signed(b_r);
      carry_s = 1'b0;
      ovf_s   = 1'b0;
      nomul_s = 1'b0;
      case (op_r)
         OP_ADD: begin
            res_a_s = sum_v[31:0];
            res_b_s = a_r - b_r;
            carry_s = sum_v[32];
            ovf_s   = (a_r[31] == b_r[31]) && (sum_v[31] != a_r[31]);
         end
         OP_MUL: begin
            if (MUL_PRESENT) begin
               res_a_s = mul_prod_s[31:0];
               res_b_s = mul_prod_s[63:32];
            end else begin
               res_a_s = 32'd0;
               res_b_s = 32'd0;
               nomul_s = 1'b1;
            end
         end
         OP_LOGIC: begin
            res_a_s = a_r & b_r;
            res_b_s = a_r ^ b_r;
         end
         OP_MINMAX: begin
            res_a_s = slt_v ? a_r : b_r;
            res_b_s = slt_v ? b_r : a_r;
         end
         default: begin
            res_a_s = 32'd0;
            res_b_s = 32'd0;
         end
      endcase
      res_c_s                   = 32'd0;
      res_c_s[C_ZERO]           = (res_a_s == 32'd0);
      res_c_s[C_CARRY]          = carry_s;
      res_c_s[C_OVF]            = ovf_s;
      res_c_s[C_NEG]            = res_a_s[31];
      res_c_s[C_SLT]            = slt_v;
      res_c_s[C_ULT]            = (a_r < b_r);
      res_c_s[C_EQ]             = (a_r == b_r);
      res_c_s[C_NOMUL]          = nomul_s;
      res_c_s[C_OVR]            = overrun_next_s;
      res_c_s[C_DLY_LO +: 4]    = dly_r;
      res_c_s[C_CNT_LO +: 12]   = cnt_r + 12'd1;
   end

   // Control state and the command latched on accept.
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         wait_r    <= 4'd0;
         done_r    <= 1'b0;
         overrun_r <= 1'b0;
         op_r      <= OP_ADD;
         a_r       <= 32'd0;
         b_r       <= 32'd0;
         dly_r     <= 4'd0;
      end else begin
         state_r   <= state_next_s;
         wait_r    <= wait_next_s;
         done_r    <= done_next_s;
         overrun_r <= overrun_next_s;
         if (accept_s) begin
            op_r  <= eFPGA_operator_i;
            a_r   <= eFPGA_operand_a_i;
            b_r   <= eFPGA_operand_b_i;
            dly_r <= eFPGA_delay_i;
         end
      end
   end

   // Result registers and completion counter, updated only on completion.
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         res_a_r <= 32'd0;
         res_b_r <= 32'd0;
         res_c_r <= 32'd0;
         cnt_r   <= 12'd0;
      end else if (complete_s) begin
         res_a_r <= res_a_s;
         res_b_r <= res_b_s;
         res_c_r <= res_c_s;
         cnt_r   <= cnt_r + 12'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign eFPGA_result_a_o  = res_a_r;
   assign eFPGA_result_b_o  = res_b_r;
   assign eFPGA_result_c_o  = res_c_r;
   assign eFPGA_fpga_done_o = done_r;

endmodule

// File: tb/tb_efpga_op_responder.sv
// Directed bench for efpga_op_responder; expectations are hand-computed.
// Covers both builds via EFPGA_RESP_MUL_EN.
module tb_efpga_op_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        strobe;
   logic [31:0] opa, opb;
   logic [1:0]  op;
   logic [3:0]  dly;
   logic [31:0] res_a, res_b, res_c;
   logic        done;

   int nvec = 0;
   int nerr = 0;

   efpga_op_responder dut (
      .clk_i                (clk),
      .reset                (reset),
      .eFPGA_en_i           (en),
      .eFPGA_write_strobe_i (strobe),
      .eFPGA_operand_a_i    (opa),
      .eFPGA_operand_b_i    (opb),
      .eFPGA_operator_i     (op),
      .eFPGA_delay_i        (dly),
      .eFPGA_result_a_o     (res_a),
      .eFPGA_result_b_o     (res_b),
      .eFPGA_result_c_o     (res_c),
      .eFPGA_fpga_done_o    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one command for exactly one rising edge (edge T); returns just after T.
   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] d);
      @(negedge clk);
      op = o; opa = a; opb = b; dly = d; strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
   endtask

   // Count edges until done rises, bounded.
   task automatic lat(input string tag, input int exp);
      int n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      logic rose;
      reset = 1'b1; en = 1'b0; strobe = 1'b0;
      opa = 32'd0; opb = 32'd0; op = 2'b00; dly = 4'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0; en = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_a", res_a, 32'd0);
      chk("rst_b", res_b, 32'd0);
      chk("rst_c", res_c, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // ADD with carry-out into zero
      issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0);
      lat("add_lat", 1);
      chk("add_a", res_a, 32'h0000_0000);
      chk("add_b", res_b, 32'hFFFF_FFFE);
      chk("add_c", res_c, 32'h0010_0013);

      // MUL, delay 3
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
      chk("mul_done_fall", {31'd0, done}, 32'd0);
`ifdef EFPGA_RESP_MUL_EN
      lat("mul_lat", 36);
      chk("mul_a", res_a, 32'h0000_0001);
      chk("mul_b", res_b, 32'hFFFF_FFFE);
      chk("mul_c", res_c, 32'h0023_0040);
`else
      lat("mul_lat", 4);
      chk("mul_a", res_a, 32'h0000_0000);
      chk("mul_b", res_b, 32'h0000_0000);
      chk("mul_c", res_c, 32'h0023_00C1);
`endif

      // MINMAX with a second strobe while busy
      issue(2'b11, 32'h8000_0000, 32'h0000_0005, 4'd2);
      op = 2'b00; opa = 32'd1; opb = 32'd1; strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      lat("mm_lat", 2);
      chk("mm_a", res_a, 32'h8000_0000);
      chk("mm_b", res_b, 32'h0000_0005);
      chk("mm_c", res_c, 32'h0032_0118);
      repeat (4) @(negedge clk);
      chk("mm_hold_done", {31'd0, done}, 32'd1);
      chk("mm_hold_a", res_a, 32'h8000_0000);

      // LOGIC, long delay, aborted by enable
      issue(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd15);
      chk("abort_done_fall", {31'd0, done}, 32'd0);
      repeat (4) @(negedge clk);
      en = 1'b0;
      rose = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rose = rose | done;
      end
      chk("abort_no_done", {31'd0, rose}, 32'd0);
      chk("abort_a", res_a, 32'h8000_0000);
      chk("abort_b", res_b, 32'h0000_0005);
      chk("abort_c", res_c, 32'h0032_0118);

      // Strobe with enable low is not an accept
      op = 2'b00; opa = 32'd9; opb = 32'd9; dly = 4'd0; strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0; en = 1'b1;
      rose = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rose = rose | done;
      end
      chk("en_wins", {31'd0, rose}, 32'd0);

      // Back-to-back ADDs
      issue(2'b00, 32'd3, 32'd4, 4'd0);
      lat("b2b1_lat", 1);
      chk("b2b1_a", res_a, 32'h0000_0007);
      chk("b2b1_b", res_b, 32'hFFFF_FFFF);
      chk("b2b1_c", res_c, 32'h0040_0030);
      issue(2'b00, 32'd10, 32'd3, 4'd0);
      chk("b2b2_fall", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("b2b2_rise", {31'd0, done}, 32'd1);
      chk("b2b2_a", res_a, 32'h0000_000D);
      chk("b2b2_b", res_b, 32'h0000_0007);
      chk("b2b2_c", res_c, 32'h0050_0000);

      // Signed overflow
      issue(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd0);
      lat("ovf_lat", 1);
      chk("ovf_a", res_a, 32'h8000_0000);
      chk("ovf_b", res_b, 32'h7FFF_FFFE);
      chk("ovf_c", res_c, 32'h0060_000C);

      // Run the completion counter to 4095, then wrap
      for (int i = 0; i < 4089; i++) begin
         issue(2'b10, 32'd0, 32'd0, 4'd0);
      end
      @(negedge clk);
      chk("cnt_4095", {20'd0, res_c[31:20]}, 32'h0000_0FFF);
      issue(2'b10, 32'd0, 32'd0, 4'd0);
      lat("wrap_lat", 1);
      chk("wrap_c", res_c, 32'h0000_0041);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
